// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Two-requester round-robin arbiter issuing one access at a time to
//            an SDRAM controller, with a bounded wait for read data.
// Revision : 1.0  initial release
// ============================================================================
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_done,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_done,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ctl_req,
    output logic                  ctl_we,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [DATA_WIDTH-1:0] ctl_wdata,
    input  logic                  ctl_ack,
    input  logic                  ctl_rvalid,
    input  logic [DATA_WIDTH-1:0] ctl_rdata
);

    localparam int CNT_WIDTH = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_armed;
    logic                  r_last;      // 1 = m1 was granted most recently
    logic                  r_sel;       // port owning the current access
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_grant;
    logic                  w_grant_sel;
    logic [1:0]            w_grant_vec;
    logic                  w_timeout;

    assign w_elig0     = r_armed[0] & m0_req;
    assign w_elig1     = r_armed[1] & m1_req;
    assign w_grant     = (r_state == IDLE) & (w_elig0 | w_elig1);
    // Under contention the port that did not win last time goes first.
    assign w_grant_sel = w_elig1 & (~w_elig0 | ~r_last);
    assign w_grant_vec = {w_grant & w_grant_sel, w_grant & ~w_grant_sel};
    assign w_timeout   = (r_state == RDWAIT) & ~ctl_rvalid & (r_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_next = ISSUE;
            end
            ISSUE: begin
                if (ctl_ack) w_state_next = r_we ? DONE : RDWAIT;
            end
            RDWAIT: begin
                if (ctl_rvalid || w_timeout) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed  <= 2'b00;
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            // A port re-arms only after its req has been seen low.
            r_armed <= (r_armed | ~{m1_req, m0_req}) & ~w_grant_vec;
            if (w_grant) begin
                r_sel   <= w_grant_sel;
                r_last  <= w_grant_sel;
                r_we    <= w_grant_sel ? m1_we    : m0_we;
                r_addr  <= w_grant_sel ? m1_addr  : m0_addr;
                r_wdata <= w_grant_sel ? m1_wdata : m0_wdata;
                r_err   <= 1'b0;
            end
            if ((r_state == ISSUE) && ctl_ack) begin
                r_cnt <= '0;
            end
            if (r_state == RDWAIT) begin
                if (ctl_rvalid) begin
                    if (r_sel) r_rdata1 <= ctl_rdata;
                    else       r_rdata0 <= ctl_rdata;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                    if (r_sel) r_rdata1 <= '0;
                    else       r_rdata0 <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign ctl_req   = (r_state == ISSUE);
    assign ctl_we    = r_we;
    assign ctl_addr  = r_addr;
    assign ctl_wdata = r_wdata;

    assign m0_done  = (r_state == DONE) & ~r_sel;
    assign m1_done  = (r_state == DONE) &  r_sel;
    assign m0_err   = m0_done & r_err;
    assign m1_err   = m1_done & r_err;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Purpose  : Self-checking bench for sdram_arbiter (directed + randomized).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_done, m0_err, m1_done, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ctl_req, ctl_we, ctl_ack, ctl_rvalid;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata, ctl_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_ack(ctl_ack), .ctl_rvalid(ctl_rvalid), .ctl_rdata(ctl_rdata)
    );

    task automatic init_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        ctl_ack = 0; ctl_rvalid = 0; ctl_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        init_inputs();
        m0_req = 1;
        do_reset();
        checks++;
        if ({ctl_req, m0_done, m1_done, m0_err, m1_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {ctl_req, m0_done, m1_done, m0_err, m1_err});
        end
        checks++;
        if ({ctl_we, ctl_addr, ctl_wdata, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_fields got we=%b addr=%h wdata=%h r0=%h r1=%h exp all 0",
                     ctl_we, ctl_addr, ctl_wdata, m0_rdata, m1_rdata);
        end
        // req held high since reset was never seen low, so it must not be served
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ctl_req !== 1'b0) begin
                errors++;
                $display("FAIL unarmed_no_grant cycle %0d got ctl_req=%b exp 0", k, ctl_req);
            end
        end
        m0_req = 0;
    endtask

    task automatic test_write_latency();
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_addr = 24'h000123; m0_wdata = 16'hBEEF; ctl_ack = 1;
        @(negedge clk);
        checks++;
        if ({ctl_req, ctl_we, ctl_addr, ctl_wdata, m0_done} !== {1'b1, 1'b1, 24'h000123, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL wr_issue got req=%b we=%b addr=%h wdata=%h done=%b exp 1 1 000123 beef 0",
                     ctl_req, ctl_we, ctl_addr, ctl_wdata, m0_done);
        end
        m0_addr = 24'hFFFFFF; m0_wdata = 16'h0000;
        @(negedge clk);
        checks++;
        if ({m0_done, m0_err, m1_done, ctl_req} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_done got done=%b err=%b m1done=%b req=%b exp 1 0 0 0",
                     m0_done, m0_err, m1_done, ctl_req);
        end
        m0_req = 0; ctl_ack = 0;
        @(negedge clk);
        checks++;
        if (m0_done !== 1'b0) begin
            errors++;
            $display("FAIL wr_done_width got done=%b exp 0", m0_done);
        end
    endtask

    task automatic test_alternation();
        logic [DW-1:0] exp_d;
        int n;
        init_inputs();
        do_reset();
        @(negedge clk);
        m0_req = 1; m1_req = 1; m0_addr = 24'h000010; m1_addr = 24'h000020;
        ctl_ack = 1; ctl_rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'(16'h1111 * (i + 1));
            ctl_rdata = exp_d;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (m0_done !== 1'b1 && m1_done !== 1'b1 && n < 20);
            checks++;
            if ({m0_done, m1_done} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_grant txn %0d got done=%b%b exp %s", i, m0_done, m1_done,
                         (i % 2 == 0) ? "m0" : "m1");
            end
            checks++;
            if (((i % 2 == 0) ? m0_rdata : m1_rdata) !== exp_d) begin
                errors++;
                $display("FAIL alt_rdata txn %0d got %h exp %h", i,
                         (i % 2 == 0) ? m0_rdata : m1_rdata, exp_d);
            end
            if (i % 2 == 0) m0_req = 0; else m1_req = 0;
            @(negedge clk);
            if (i % 2 == 0) m0_req = 1; else m1_req = 1;
        end
        m0_req = 0; m1_req = 0; ctl_ack = 0; ctl_rvalid = 0;
        @(negedge clk);
    endtask

    task automatic test_read_delay();
        logic [AW-1:0] a;
        int bad;
        a = AW'($urandom);
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = a;
        @(negedge clk);
        checks++;
        if ({ctl_req, ctl_we, ctl_addr} !== {1'b1, 1'b0, a}) begin
            errors++;
            $display("FAIL rd_issue got req=%b we=%b addr=%h exp 1 0 %h", ctl_req, ctl_we, ctl_addr, a);
        end
        ctl_ack = 1; ctl_rvalid = 1; ctl_rdata = 16'hDEAD;
        m1_addr = ~a;
        @(negedge clk);
        ctl_ack = 0; ctl_rvalid = 0;
        checks++;
        if (ctl_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_drop got ctl_req=%b exp 0", ctl_req);
        end
        bad = 0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            ctl_ack = (k == 3);
            if (m1_done !== 1'b0 || ctl_req !== 1'b0) bad++;
            if (k == 7) begin
                ctl_ack = 0; ctl_rvalid = 1; ctl_rdata = 16'hA5A5;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rd_wait_quiet got %0d bad cycles exp 0", bad);
        end
        @(negedge clk);
        ctl_rvalid = 0;
        checks++;
        if ({m1_done, m1_err, m1_rdata, m0_done} !== {1'b1, 1'b0, 16'hA5A5, 1'b0}) begin
            errors++;
            $display("FAIL rd_done got done=%b err=%b rdata=%h m0done=%b exp 1 0 a5a5 0",
                     m1_done, m1_err, m1_rdata, m0_done);
        end
        checks++;
        if (m0_rdata !== 16'h3333) begin
            errors++;
            $display("FAIL rd_other_hold got m0_rdata=%h exp 3333", m0_rdata);
        end
        m1_req = 0;
        @(negedge clk);
        checks++;
        if ({m1_done, m1_rdata} !== {1'b0, 16'hA5A5}) begin
            errors++;
            $display("FAIL rd_hold got done=%b rdata=%h exp 0 a5a5", m1_done, m1_rdata);
        end
    endtask

    task automatic test_timeout();
        int bad;
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = AW'($urandom); ctl_ack = 1;
        @(negedge clk);
        checks++;
        if (ctl_req !== 1'b1) begin
            errors++;
            $display("FAIL to_issue got ctl_req=%b exp 1", ctl_req);
        end
        bad = 0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            ctl_ack = 0;
            if (m0_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL to_early_done got %0d done cycles in wait exp 0", bad);
        end
        @(negedge clk);
        checks++;
        if ({m0_done, m0_err, m0_rdata, m1_done} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL to_done got done=%b err=%b rdata=%h m1done=%b exp 1 1 0000 0",
                     m0_done, m0_err, m0_rdata, m1_done);
        end
        m0_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_done, m0_err} !== 2'b00) begin
            errors++;
            $display("FAIL to_clear got done=%b err=%b exp 0 0", m0_done, m0_err);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_addr = AW'($urandom); ctl_ack = 1;
        @(negedge clk);
        @(negedge clk);
        ctl_ack = 0;
        @(negedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        checks++;
        if ({ctl_req, ctl_we, ctl_addr, ctl_wdata, m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got req=%b addr=%h r0=%h r1=%h done=%b%b exp all 0",
                     ctl_req, ctl_addr, m0_rdata, m1_rdata, m0_done, m1_done);
        end
        ctl_rvalid = 1; ctl_rdata = 16'h7777;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m0_done !== 1'b0 || m1_done !== 1'b0 || ctl_req !== 1'b0 || m1_rdata !== 16'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_quiet got %0d bad cycles exp 0", bad);
        end
        ctl_rvalid = 0; m1_req = 0;
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_wdata = 16'h5A5A; ctl_ack = 1;
        @(negedge clk);
        checks++;
        if ({ctl_req, ctl_we, ctl_wdata} !== {1'b1, 1'b1, 16'h5A5A}) begin
            errors++;
            $display("FAIL midrst_new_issue got req=%b we=%b wdata=%h exp 1 1 5a5a", ctl_req, ctl_we, ctl_wdata);
        end
        @(negedge clk);
        checks++;
        if ({m1_done, m1_err} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_new_done got done=%b err=%b exp 1 0", m1_done, m1_err);
        end
        m1_req = 0; ctl_ack = 0;
        @(negedge clk);
    endtask

    task automatic test_rearm();
        int bad;
        m0_req = 1; m0_we = 1; m0_wdata = DW'($urandom); ctl_ack = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m0_done !== 1'b1) begin
            errors++;
            $display("FAIL rearm_first got done=%b exp 1", m0_done);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ctl_req !== 1'b0 || m0_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rearm_hold got %0d accesses while req held exp 0", bad);
        end
        m0_req = 0;
        @(negedge clk);
        m0_req = 1;
        @(negedge clk);
        checks++;
        if (ctl_req !== 1'b1) begin
            errors++;
            $display("FAIL rearm_grant got ctl_req=%b exp 1", ctl_req);
        end
        m0_req = 0; ctl_ack = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Transaction-level model: pending requests, round-robin on contention,
    // per-port last read value.
    task automatic test_random();
        logic          pend [2];
        logic          we_q [2];
        logic [AW-1:0] addr_q [2];
        logic [DW-1:0] wd_q [2];
        logic [DW-1:0] rd_model [2];
        logic [DW-1:0] rv;
        int            last, win, n, d;
        init_inputs();
        do_reset();
        last = 1;
        pend = '{1'b0, 1'b0};
        rd_model = '{16'h0, 16'h0};
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) pend[p] = 1'b1;
            end
            if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && !(p == 0 ? m0_req : m1_req)) begin
                    we_q[p]   = 1'($urandom_range(0, 1));
                    addr_q[p] = AW'($urandom);
                    wd_q[p]   = DW'($urandom);
                end
            end
            m0_req = pend[0]; m0_we = we_q[0]; m0_addr = addr_q[0]; m0_wdata = wd_q[0];
            m1_req = pend[1]; m1_we = we_q[1]; m1_addr = addr_q[1]; m1_wdata = wd_q[1];
            win  = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            last = win;
            n = 0;
            while (ctl_req !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (ctl_req !== 1'b1) begin
                errors++;
                $display("FAIL rand_issue it=%0d got ctl_req=%b exp 1", it, ctl_req);
                return;
            end
            checks++;
            if ({ctl_we, ctl_addr, ctl_wdata} !== {we_q[win], addr_q[win], wd_q[win]}) begin
                errors++;
                $display("FAIL rand_fields it=%0d got %b %h %h exp m%0d %b %h %h", it,
                         ctl_we, ctl_addr, ctl_wdata, win, we_q[win], addr_q[win], wd_q[win]);
            end
            if (win == 0) begin
                m0_we = ~we_q[0]; m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
            end else begin
                m1_we = ~we_q[1]; m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
            end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            checks++;
            if ({ctl_req, ctl_we, ctl_addr, ctl_wdata} !== {1'b1, we_q[win], addr_q[win], wd_q[win]}) begin
                errors++;
                $display("FAIL rand_stable it=%0d got req=%b addr=%h exp 1 %h", it, ctl_req, ctl_addr, addr_q[win]);
            end
            ctl_ack = 1;
            @(negedge clk);
            ctl_ack = 0;
            if (!we_q[win]) begin
                d = $urandom_range(0, 12);
                repeat (d) @(negedge clk);
                rv = DW'($urandom);
                ctl_rvalid = 1; ctl_rdata = rv;
                @(negedge clk);
                ctl_rvalid = 0;
                rd_model[win] = rv;
            end
            checks++;
            if ({m0_done, m1_done, m0_err, m1_err, ctl_req} !== {(win == 0), (win == 1), 3'b000}) begin
                errors++;
                $display("FAIL rand_done it=%0d got done=%b%b err=%b%b req=%b exp m%0d", it,
                         m0_done, m1_done, m0_err, m1_err, ctl_req, win);
            end
            checks++;
            if ({m0_rdata, m1_rdata} !== {rd_model[0], rd_model[1]}) begin
                errors++;
                $display("FAIL rand_rdata it=%0d got %h %h exp %h %h", it,
                         m0_rdata, m1_rdata, rd_model[0], rd_model[1]);
            end
            pend[win] = 1'b0;
            if (win == 0) m0_req = 0; else m1_req = 0;
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_alternation();
        test_read_delay();
        test_timeout();
        test_reset_mid();
        test_rearm();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
